// File: rtl/lsu_axi_master.sv
// Load/store unit front end: takes one EXU memory request at a time,
// checks alignment, and runs it as a single-beat AXI read or write.
// Byte/half lanes are placed or extracted here, so the slave always sees
// word-aligned addresses.
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  // EXU request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  // EXU response side
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI read channels
  output logic [31:0] maxi_araddr,
  output logic        maxi_arvalid,
  input  logic        maxi_arready,
  input  logic [31:0] maxi_rdata,
  input  logic        maxi_rvalid,
  output logic        maxi_rready,
  // AXI write channels
  output logic [31:0] maxi_awaddr,
  output logic        maxi_awvalid,
  input  logic        maxi_awready,
  output logic [31:0] maxi_wdata,
  output logic        maxi_wvalid,
  input  logic        maxi_wready,
  input  logic        maxi_bvalid,
  output logic        maxi_bready,
  output logic [7:0]  wmask
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        aw_done;
  logic        w_done;

  logic        accept;
  logic        misalign;
  logic        aw_fire;
  logic        w_fire;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic [31:0] st_data;
  logic [3:0]  st_mask;

  // Holding off req_ready while the response pulses keeps the next
  // acceptance at least one cycle after resp_valid.
  assign req_ready    = (state == IDLE) && !resp_valid;
  assign accept       = req_valid && req_ready;

  assign maxi_araddr  = {addr_q[31:2], 2'b00};
  assign maxi_awaddr  = {addr_q[31:2], 2'b00};
  assign maxi_arvalid = (state == RADDR);
  assign maxi_rready  = (state == RDATA);
  assign maxi_awvalid = (state == WRITE) && !aw_done;
  assign maxi_wvalid  = (state == WRITE) && !w_done;
  assign maxi_bready  = (state == WRESP);
  assign maxi_wdata   = wdata_q;
  assign wmask        = {4'b0000, mask_q};

  assign aw_fire      = maxi_awvalid && maxi_awready;
  assign w_fire       = maxi_wvalid && maxi_wready;

  // Alignment check on the incoming request.
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // Store lane placement: shift data and byte enables to the addressed lane.
  always_comb begin
    st_data = req_wdata << {req_addr[1:0], 3'b000};
    case (req_size)
      2'b00:   st_mask = 4'b0001 << req_addr[1:0];
      2'b01:   st_mask = 4'b0011 << req_addr[1:0];
      default: st_mask = 4'b1111;
    endcase
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    rd_shift = maxi_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h000000, rd_shift[7:0]}
                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = uns_q ? {16'h0000, rd_shift[15:0]}
                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = maxi_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misalign)     state_next = ERR;
          else if (req_wen) state_next = WRITE;
          else              state_next = RADDR;
        end
      end
      RADDR: if (maxi_arready) state_next = RDATA;
      RDATA: if (maxi_rvalid)  state_next = IDLE;
      WRITE: if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WRESP;
      WRESP: if (maxi_bvalid)  state_next = IDLE;
      ERR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, write-channel bookkeeping and registered responses.
  // An error response is raised at acceptance so it shows during the ERR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      mask_q     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (misalign) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else if (req_wen) begin
          wdata_q <= st_data;
          mask_q  <= st_mask;
        end
      end
      if (state == WRITE) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if ((state == RDATA) && maxi_rvalid) begin
        resp_rdata <= load_val;
        resp_valid <= 1'b1;
      end
      if ((state == WRESP) && maxi_bvalid) begin
        resp_valid <= 1'b1;
        mask_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master. Inputs change and outputs are
// sampled on the falling clock edge; the slave is driven by hand.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] maxi_araddr;
  logic        maxi_arvalid;
  logic        maxi_arready = 1'b0;
  logic [31:0] maxi_rdata = '0;
  logic        maxi_rvalid = 1'b0;
  logic        maxi_rready;
  logic [31:0] maxi_awaddr;
  logic        maxi_awvalid;
  logic        maxi_awready = 1'b0;
  logic [31:0] maxi_wdata;
  logic        maxi_wvalid;
  logic        maxi_wready = 1'b0;
  logic        maxi_bvalid = 1'b0;
  logic        maxi_bready;
  logic [7:0]  wmask;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid), .maxi_arready(maxi_arready),
    .maxi_rdata(maxi_rdata), .maxi_rvalid(maxi_rvalid), .maxi_rready(maxi_rready),
    .maxi_awaddr(maxi_awaddr), .maxi_awvalid(maxi_awvalid), .maxi_awready(maxi_awready),
    .maxi_wdata(maxi_wdata), .maxi_wvalid(maxi_wvalid), .maxi_wready(maxi_wready),
    .maxi_bvalid(maxi_bvalid), .maxi_bready(maxi_bready), .wmask(wmask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge, confirm it is offered, and leave
  // the bench at the falling edge after acceptance.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wd;
    req_size     = size;
    req_unsigned = uns;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_arvalid", {31'b0, maxi_arvalid}, 32'd0);
    check("rst_awvalid", {31'b0, maxi_awvalid}, 32'd0);
    check("rst_wvalid",  {31'b0, maxi_wvalid},  32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_wmask", {24'b0, wmask}, 32'h0);
    check("rst_wdata", maxi_wdata, 32'h0);
    check("rst_awaddr", maxi_awaddr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Signed byte load from the top lane, zero-wait slave
    issue(1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b0);
    check("lb_arvalid", {31'b0, maxi_arvalid}, 32'd1);
    check("lb_araddr", maxi_araddr, 32'h8000_0000);
    maxi_arready = 1'b1;
    @(negedge clk);
    maxi_arready = 1'b0;
    check("lb_arvalid_drop", {31'b0, maxi_arvalid}, 32'd0);
    check("lb_rready", {31'b0, maxi_rready}, 32'd1);
    maxi_rvalid = 1'b1;
    maxi_rdata  = 32'h80FF_1234;
    @(negedge clk);
    maxi_rvalid = 1'b0;
    check("lb_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("lb_resp_err", {31'b0, resp_err}, 32'd0);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    check("lb_no_accept_during_resp", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("lb_pulse_end", {31'b0, resp_valid}, 32'd0);
    check("lb_rdata_hold", resp_rdata, 32'hFFFF_FF80);

    // Unsigned half load, arready delayed three cycles; stray bvalid ignored
    issue(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b1);
    maxi_bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("lhu_arvalid_hold", {31'b0, maxi_arvalid}, 32'd1);
      check("lhu_araddr_hold", maxi_araddr, 32'h8000_0000);
      @(negedge clk);
    end
    maxi_bvalid = 1'b0;
    check("lhu_no_resp_wait", {31'b0, resp_valid}, 32'd0);
    maxi_arready = 1'b1;
    @(negedge clk);
    maxi_arready = 1'b0;
    maxi_rvalid  = 1'b1;
    maxi_rdata   = 32'hBEEF_0000;
    @(negedge clk);
    maxi_rvalid = 1'b0;
    check("lhu_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("lhu_rdata", resp_rdata, 32'h0000_BEEF);
    @(negedge clk);

    // Byte store, awready two cycles ahead of wready; stray rvalid ignored
    issue(1'b1, 32'h8000_0001, 32'h0000_00AB, 2'b00, 1'b0);
    check("sb_awvalid", {31'b0, maxi_awvalid}, 32'd1);
    check("sb_wvalid", {31'b0, maxi_wvalid}, 32'd1);
    check("sb_awaddr", maxi_awaddr, 32'h8000_0000);
    check("sb_wdata", maxi_wdata, 32'h0000_AB00);
    check("sb_wmask", {24'b0, wmask}, 32'h02);
    maxi_awready = 1'b1;
    @(negedge clk);
    maxi_awready = 1'b0;
    maxi_rvalid  = 1'b1;
    maxi_rdata   = 32'h1111_1111;
    check("sb_aw_drop", {31'b0, maxi_awvalid}, 32'd0);
    check("sb_w_hold", {31'b0, maxi_wvalid}, 32'd1);
    @(negedge clk);
    maxi_rvalid = 1'b0;
    check("sb_w_hold2", {31'b0, maxi_wvalid}, 32'd1);
    check("sb_no_bready_yet", {31'b0, maxi_bready}, 32'd0);
    maxi_wready = 1'b1;
    @(negedge clk);
    maxi_wready = 1'b0;
    check("sb_w_drop", {31'b0, maxi_wvalid}, 32'd0);
    check("sb_bready", {31'b0, maxi_bready}, 32'd1);
    check("sb_wmask_wresp", {24'b0, wmask}, 32'h02);
    check("sb_no_early_resp", {31'b0, resp_valid}, 32'd0);
    maxi_bvalid = 1'b1;
    @(negedge clk);
    maxi_bvalid = 1'b0;
    check("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("sb_resp_err", {31'b0, resp_err}, 32'd0);
    check("sb_rdata_kept", resp_rdata, 32'h0000_BEEF);
    @(negedge clk);
    check("sb_single_pulse", {31'b0, resp_valid}, 32'd0);

    // Word store, both channels handshake in the first cycle
    issue(1'b1, 32'h8000_0008, 32'hCAFE_F00D, 2'b10, 1'b0);
    check("sw_wdata", maxi_wdata, 32'hCAFE_F00D);
    check("sw_wmask", {24'b0, wmask}, 32'h0F);
    maxi_awready = 1'b1;
    maxi_wready  = 1'b1;
    @(negedge clk);
    maxi_awready = 1'b0;
    maxi_wready  = 1'b0;
    check("sw_bready", {31'b0, maxi_bready}, 32'd1);
    maxi_bvalid = 1'b1;
    @(negedge clk);
    maxi_bvalid = 1'b0;
    check("sw_resp_valid", {31'b0, resp_valid}, 32'd1);
    @(negedge clk);

    // Misaligned word load takes the error path
    issue(1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0);
    check("err_arvalid", {31'b0, maxi_arvalid}, 32'd0);
    check("err_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("err_resp_err", {31'b0, resp_err}, 32'd1);
    @(negedge clk);
    check("err_pulse_end", {31'b0, resp_valid}, 32'd0);
    check("err_req_ready", {31'b0, req_ready}, 32'd1);
    check("err_rdata_kept", resp_rdata, 32'h0000_BEEF);

    // Reset while waiting in RDATA
    issue(1'b0, 32'h8000_0004, 32'h0, 2'b10, 1'b0);
    maxi_arready = 1'b1;
    @(negedge clk);
    maxi_arready = 1'b0;
    check("mid_rready", {31'b0, maxi_rready}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rready_rst", {31'b0, maxi_rready}, 32'd0);
    check("mid_arvalid_rst", {31'b0, maxi_arvalid}, 32'd0);
    maxi_rvalid = 1'b1;
    maxi_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    maxi_rvalid = 1'b0;
    rst = 1'b0;
    check("mid_no_resp", {31'b0, resp_valid}, 32'd0);
    check("mid_rdata_clr", resp_rdata, 32'h0);
    @(negedge clk);
    check("mid_no_resp2", {31'b0, resp_valid}, 32'd0);

    // Load after reset completes normally; signed half at lane 0
    issue(1'b0, 32'h8000_0004, 32'h0, 2'b01, 1'b0);
    check("post_araddr", maxi_araddr, 32'h8000_0004);
    maxi_arready = 1'b1;
    @(negedge clk);
    maxi_arready = 1'b0;
    maxi_rvalid  = 1'b1;
    maxi_rdata   = 32'h1234_8001;
    @(negedge clk);
    maxi_rvalid = 1'b0;
    check("post_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("post_rdata", resp_rdata, 32'hFFFF_8001);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
